// File: rtl/note_scroll_controller.sv
// Note scroll controller.
// Holds NUM_SLOTS falling note objects. On each frame tick it scans the slots
// one per cycle, moves every active note down by 'speed' pixels and retires
// any note that reaches SCREEN_H, reporting it as a miss. Notes are spawned
// into the lowest free slot while idle and can be struck (cleared) at any time.
module note_scroll_controller #(
    parameter int NUM_SLOTS = 8,
    parameter int SCREEN_H  = 480
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         frame_tick,
    input  logic [3:0]                   speed,
    input  logic                         spawn_valid,
    input  logic [9:0]                   spawn_x,
    output logic                         spawn_ready,
    input  logic                         hit_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
    output logic [NUM_SLOTS-1:0]         slot_active,
    output logic [10*NUM_SLOTS-1:0]      slot_x,
    output logic [10*NUM_SLOTS-1:0]      slot_y,
    output logic                         busy,
    output logic                         miss_pulse,
    output logic [7:0]                   miss_count
);

    localparam int                IDX_W    = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [10:0]       RETIRE_Y = 11'(SCREEN_H);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  next_idx;
    logic              pending;
    logic              next_pending;

    logic [NUM_SLOTS-1:0] active;
    logic [9:0]           x_mem [NUM_SLOTS];
    logic [9:0]           y_mem [NUM_SLOTS];
    logic [7:0]           miss_cnt;

    // Scan datapath for the slot addressed this cycle.
    logic [9:0]        scan_y;
    logic [10:0]       scan_sum;
    logic              scan_hit;
    logic              scan_live;
    logic              scan_retire;
    logic              scan_advance;

    // Spawn allocation.
    logic [IDX_W-1:0]  free_idx;
    logic              any_free;
    logic              spawn_fire;

    assign scan_y       = y_mem[scan_idx];
    assign scan_sum     = {1'b0, scan_y} + {7'd0, speed};
    // A strike on the slot being scanned wins: the note is cleared, not missed.
    assign scan_hit     = hit_valid && (hit_slot == scan_idx);
    assign scan_live    = (state == SCAN) && active[scan_idx] && !scan_hit;
    assign scan_retire  = scan_live && (scan_sum >= RETIRE_Y);
    assign scan_advance = scan_live && !scan_retire;

    assign any_free     = ~&active;
    assign spawn_ready  = (state == IDLE) && any_free;
    assign spawn_fire   = spawn_valid && spawn_ready;

    assign busy         = (state == SCAN);
    assign miss_pulse   = scan_retire;

    // State register, scan index and pending-tick flag.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            scan_idx <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= next_state;
            scan_idx <= next_idx;
            pending  <= next_pending;
        end
    end

    // Next-state logic: idle until a tick, then one slot per cycle; a tick seen
    // mid-scan chains a fresh scan straight after the last slot.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state   = state;
        next_idx     = scan_idx;
        next_pending = pending;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    next_state = SCAN;
                    next_idx   = '0;
                end
            end
            SCAN: begin
                if (scan_idx == LAST_IDX) begin
                    next_idx = '0;
                    if (pending || frame_tick) begin
                        next_pending = 1'b0;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_idx = scan_idx + IDX_W'(1);
                    if (frame_tick) begin
                        next_pending = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // Lowest-index inactive slot, used as the spawn target.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Slot storage: scan moves/retires, hits clear, spawns load.
    // Spawn only targets an inactive slot, so a hit never competes with it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            active <= '0;
            // NOTE: the slot arrays are small flop banks wired straight to outputs,
            // so they are reset here rather than left uninitialised like a RAM.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
        end else begin
            if (scan_retire) begin
                active[scan_idx] <= 1'b0;
            end
            if (scan_advance) begin
                y_mem[scan_idx] <= scan_sum[9:0];
            end
            if (hit_valid) begin
                active[hit_slot] <= 1'b0;
            end
            if (spawn_fire) begin
                active[free_idx] <= 1'b1;
                x_mem[free_idx]  <= spawn_x;
                y_mem[free_idx]  <= '0;
            end
        end
    end

    // Saturating miss counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            miss_cnt <= '0;
        end else if (miss_pulse && (miss_cnt != 8'hFF)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

    // Pack slot storage onto the renderer-facing buses.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign slot_x[10*g +: 10] = x_mem[g];
        assign slot_y[10*g +: 10] = y_mem[g];
    end

    assign slot_active = active;
    assign miss_count  = miss_cnt;

endmodule

// File: tb/tb_note_scroll_controller.sv
// Self-checking bench for note_scroll_controller: directed scenarios plus a
// randomized phase, all checked against a per-cycle behavioural model.
module tb_note_scroll_controller;

    localparam int N = 8;
    localparam int H = 480;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           frame_tick = 1'b0;
    logic [3:0]     speed = 4'd0;
    logic           spawn_valid = 1'b0;
    logic [9:0]     spawn_x = 10'd0;
    logic           spawn_ready;
    logic           hit_valid = 1'b0;
    logic [2:0]     hit_slot = 3'd0;
    logic [N-1:0]   slot_active;
    logic [10*N-1:0] slot_x;
    logic [10*N-1:0] slot_y;
    logic           busy;
    logic           miss_pulse;
    logic [7:0]     miss_count;

    note_scroll_controller #(.NUM_SLOTS(N), .SCREEN_H(H)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .speed       (speed),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_ready (spawn_ready),
        .hit_valid   (hit_valid),
        .hit_slot    (hit_slot),
        .slot_active (slot_active),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .busy        (busy),
        .miss_pulse  (miss_pulse),
        .miss_count  (miss_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: slot contents, scan position (-1 = not scanning),
    // queued frame flag and miss total.
    bit m_act [N];
    int m_x   [N];
    int m_y   [N];
    int m_scan;
    bit m_pend;
    int m_miss;

    logic obs_busy;
    logic obs_miss;
    logic obs_ready;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_scan = -1;
        m_pend = 1'b0;
        m_miss = 0;
    endtask

    function automatic logic [N-1:0] act_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [10*N-1:0] act_mask();
        logic [10*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (m_act[i]) v[10*i +: 10] = 10'h3FF;
        return v;
    endfunction

    function automatic logic [10*N-1:0] xvec();
        logic [10*N-1:0] v;
        for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [10*N-1:0] yvec();
        logic [10*N-1:0] v;
        for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_y[i]);
        return v;
    endfunction

    // One clock cycle: check combinational outputs mid-cycle, step the model,
    // then check registered outputs just after the edge and drop the pulses.
    task automatic cycle();
        int  free_idx;
        bit  any_free;
        bit  exp_miss;
        bit  struck;
        int  s;
        int  sum;
        @(negedge clock);
        any_free = 1'b0;
        free_idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m_act[i]) begin
                any_free = 1'b1;
                free_idx = i;
            end
        end
        exp_miss = 1'b0;
        struck   = 1'b0;
        sum      = 0;
        s        = m_scan;
        if (m_scan >= 0) begin
            struck = hit_valid && (int'(hit_slot) == s);
            sum    = m_y[s] + int'(speed);
            exp_miss = m_act[s] && !struck && (sum >= H);
        end
        obs_busy  = busy;
        obs_miss  = miss_pulse;
        obs_ready = spawn_ready;
        check("busy", 128'(busy), 128'(m_scan >= 0));
        check("spawn_ready", 128'(spawn_ready), 128'((m_scan < 0) && any_free));
        check("miss_pulse", 128'(miss_pulse), 128'(exp_miss));

        if (m_scan >= 0 && m_act[s] && !struck) begin
            if (sum >= H) begin
                m_act[s] = 1'b0;
                if (m_miss < 255) m_miss++;
            end else begin
                m_y[s] = sum;
            end
        end
        if (hit_valid) m_act[int'(hit_slot)] = 1'b0;
        if (spawn_valid && m_scan < 0 && any_free) begin
            m_act[free_idx] = 1'b1;
            m_x[free_idx]   = int'(spawn_x);
            m_y[free_idx]   = 0;
        end
        if (m_scan < 0) begin
            if (frame_tick) m_scan = 0;
        end else if (m_scan == N - 1) begin
            if (m_pend || frame_tick) begin
                m_scan = 0;
                m_pend = 1'b0;
            end else begin
                m_scan = -1;
            end
        end else begin
            m_scan++;
            if (frame_tick) m_pend = 1'b1;
        end

        @(posedge clock);
        #1;
        check("slot_active", 128'(slot_active), 128'(act_vec()));
        check("slot_x", 128'(slot_x & act_mask()), 128'(xvec() & act_mask()));
        check("slot_y", 128'(slot_y & act_mask()), 128'(yvec() & act_mask()));
        check("miss_count", 128'(miss_count), 128'(m_miss));
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        hit_valid   = 1'b0;
    endtask

    // One isolated frame: tick in idle, full scan, one idle cycle.
    task automatic frame(input logic [3:0] spd, output int nbusy, output int nmiss);
        nbusy = 0;
        nmiss = 0;
        speed = spd;
        frame_tick = 1'b1;
        repeat (10) begin
            cycle();
            nbusy += int'(obs_busy);
            nmiss += int'(obs_miss);
        end
        check("busy_per_frame", 128'(nbusy), 128'(8));
    endtask

    task automatic apply_reset();
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        hit_valid   = 1'b0;
        resetn      = 1'b0;
        #1;
        model_reset();
        check("rst_active", 128'(slot_active), 128'(0));
        check("rst_x", 128'(slot_x), 128'(0));
        check("rst_y", 128'(slot_y), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_miss_pulse", 128'(miss_pulse), 128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic spawn_n(input int n);
        for (int i = 0; i < n; i++) begin
            spawn_valid = 1'b1;
            spawn_x = 10'($urandom_range(0, 1023));
            cycle();
        end
    endtask

    initial begin
        int nb;
        int nm;
        logic [19:0] run;

        model_reset();
        apply_reset();
        check("rst_ready", 128'(spawn_ready), 128'(1));

        // Spawn at x=100, three frames at speed 4.
        spawn_valid = 1'b1;
        spawn_x = 10'd100;
        cycle();
        repeat (3) frame(4'd4, nb, nm);
        check("s1_active0", 128'(slot_active[0]), 128'(1));
        check("s1_x0", 128'(slot_x[9:0]), 128'(100));
        check("s1_y0", 128'(slot_y[9:0]), 128'(12));

        // Retirement threshold: one note at 476 retires, one at 475 survives.
        apply_reset();
        spawn_n(1);
        frame(4'd1, nb, nm);
        spawn_n(1);
        repeat (31) frame(4'd15, nb, nm);
        frame(4'd10, nb, nm);
        check("s3_y0_pre", 128'(slot_y[9:0]), 128'(476));
        check("s3_y1_pre", 128'(slot_y[19:10]), 128'(475));
        frame(4'd4, nb, nm);
        check("s3_one_pulse", 128'(nm), 128'(1));
        check("s3_active", 128'(slot_active), 128'(8'b0000_0010));
        check("s3_y1", 128'(slot_y[19:10]), 128'(479));
        check("s3_miss_count", 128'(miss_count), 128'(1));

        // Full table, held spawn, hit frees slot 3 for the held request.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            spawn_valid = 1'b1;
            spawn_x = 10'(200 + i);
            cycle();
        end
        spawn_valid = 1'b1;
        spawn_x = 10'd555;
        cycle();
        check("s2_full_not_ready", 128'(obs_ready), 128'(0));
        spawn_valid = 1'b1;
        spawn_x = 10'd555;
        hit_valid = 1'b1;
        hit_slot = 3'd3;
        cycle();
        check("s2_slot3_cleared", 128'(slot_active), 128'(8'hF7));
        spawn_valid = 1'b1;
        spawn_x = 10'd555;
        cycle();
        check("s2_ready_again", 128'(obs_ready), 128'(1));
        check("s2_refill", 128'(slot_active), 128'(8'hFF));
        check("s2_slot3_x", 128'(slot_x[39:30]), 128'(555));

        // Tick during scan chains a second scan; a third tick is dropped.
        apply_reset();
        spawn_n(2);
        speed = 4'd3;
        frame_tick = 1'b1;
        cycle();
        for (int k = 0; k < 20; k++) begin
            if (k == 2 || k == 4) frame_tick = 1'b1;
            cycle();
            run[k] = obs_busy;
        end
        check("s4_busy_run", 128'(run), 128'(20'h0FFFF));
        check("s4_y0", 128'(slot_y[9:0]), 128'(6));

        // Hit on slot 5 in the cycle the scan would retire it.
        apply_reset();
        spawn_n(N);
        repeat (31) frame(4'd15, nb, nm);
        frame(4'd11, nb, nm);
        speed = 4'd4;
        frame_tick = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) begin
            if (i == 5) begin
                hit_valid = 1'b1;
                hit_slot = 3'd5;
            end
            cycle();
            if (i == 5) check("s5_hit_no_miss", 128'(obs_miss), 128'(0));
        end
        cycle();
        check("s5_all_cleared", 128'(slot_active), 128'(0));
        check("s5_miss_count", 128'(miss_count), 128'(7));

        // Miss counter saturation.
        speed = 4'd15;
        for (int b = 0; b < 32; b++) begin
            spawn_n(N);
            for (int c = 0; c < 33 * N; c++) begin
                frame_tick = 1'b1;
                cycle();
            end
            repeat (10) cycle();
        end
        check("s5_saturated", 128'(miss_count), 128'(255));

        // Randomized traffic.
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            speed       = 4'($urandom_range(0, 15));
            spawn_valid = ($urandom_range(0, 2) == 0);
            spawn_x     = 10'($urandom_range(0, 1023));
            hit_valid   = ($urandom_range(0, 5) == 0);
            hit_slot    = 3'($urandom_range(0, N - 1));
            frame_tick  = ($urandom_range(0, 11) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of a scan.
        apply_reset();
        spawn_n(4);
        speed = 4'd5;
        frame_tick = 1'b1;
        cycle();
        cycle();
        cycle();
        #2;
        apply_reset();
        cycle();
        check("s6_ready", 128'(obs_ready), 128'(1));
        check("s6_busy", 128'(obs_busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_scroll_controller.md
NOTE_SCROLL_CONTROLLER -- requirements
Module: note_scroll_controller

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, number of note object slots (power of two, 2..16).
REQ-002 SHALL have parameter SCREEN_H, default 480, retirement threshold in y pixels.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port speed  input  4  pixels added to each active note's y per frame.
REQ-007 SHALL have port spawn_valid  input  1  spawn request.
REQ-008 SHALL have port spawn_x  input  10  x of note to spawn.
REQ-009 SHALL have port spawn_ready  output  1  spawn can be accepted this cycle.
REQ-010 SHALL have port hit_valid  input  1  request to clear a slot (note struck).
REQ-011 SHALL have port hit_slot  input  log2(NUM_SLOTS)  slot to clear.
REQ-012 SHALL have port slot_active  output  NUM_SLOTS  per-slot active flag.
REQ-013 SHALL have port slot_x  output  10*NUM_SLOTS  packed x, slot i at bits [10i+9:10i].
REQ-014 SHALL have port slot_y  output  10*NUM_SLOTS  packed y, same packing.
REQ-015 SHALL have port busy  output  1  high while frame update scan is in progress.
REQ-016 SHALL have port miss_pulse  output  1  one-cycle pulse per note retired off-screen.
REQ-017 SHALL have port miss_count  output  8  saturating count of misses.

Function
REQ-018 SHALL implement FSM with states IDLE and SCAN; slot_x/slot_y/slot_active are registered and drive the per-slot bounds checkers of the renderer directly.
REQ-019 SHALL, in IDLE on frame_tick, enter SCAN next cycle with scan index 0.
REQ-020 SHALL, in SCAN, process exactly one slot per cycle, index 0..NUM_SLOTS-1, returning to IDLE after last slot; busy high in all SCAN cycles (NUM_SLOTS cycles per frame).
REQ-021 SHALL, for an active scanned slot, form 11-bit sum y+speed; if sum >= SCREEN_H clear active and pulse miss_pulse that cycle, else write sum[9:0] to y.
REQ-022 SHALL leave inactive slots unchanged during scan.
REQ-023 SHALL latch a frame_tick arriving during SCAN into a pending flag and start a new scan from index 0 the cycle after the current scan ends; further ticks while pending is set are dropped.
REQ-024 SHALL assert spawn_ready combinationally iff state is IDLE, no frame_tick this cycle is ignored (tick does not block), and at least one slot is inactive.
REQ-025 SHALL, on spawn_valid&&spawn_ready, load lowest-index inactive slot with x=spawn_x, y=0, active=1 at next edge.
REQ-026 SHALL hold spawn_valid requests without acceptance while spawn_ready is low; no request is queued internally.
REQ-027 SHALL, on hit_valid in any state, clear slot_active[hit_slot] at next edge; hit on an inactive slot has no effect.
REQ-028 SHALL give hit priority when the scan retires the same slot in the same cycle: slot cleared, no miss_pulse, no miss_count increment.
REQ-029 SHALL treat spawn and hit in the same cycle independently; a slot freed by hit is not eligible for spawn until the following cycle.
REQ-030 SHALL increment miss_count on each miss_pulse, saturating at 255.
REQ-031 SHALL not modify x of any slot except on spawn.

Reset
REQ-032 SHALL, on resetn low, immediately set state IDLE, scan index 0, pending 0, all slot_active 0, all slot_x and slot_y 0, miss_pulse 0, miss_count 0, busy 0.
REQ-033 SHALL abandon any in-progress scan on reset; no partial update or miss survives.

Verification
REQ-034 Bench: reset, spawn_x=100 accepted, speed=4, 3 frame_ticks -> slot 0 active, x=100, y=12; busy high exactly 8 cycles per tick.
REQ-035 Bench: 8 spawns accepted -> spawn_ready=0 with spawn_valid held; hit_slot=3 -> next cycle slot 3 inactive, cycle after spawn_ready=1 and next spawn lands in slot 3.
REQ-036 Bench: slot y=476, speed=4, frame_tick -> slot retired in its scan cycle, single miss_pulse, miss_count=1; y=475 -> y=479, stays active.
REQ-037 Bench: frame_tick on scan cycle 2, then second tick -> exactly two scans total, second starting cycle after first ends (16 consecutive busy cycles).
REQ-038 Bench: hit_valid on slot 5 in same cycle scan retires slot 5 -> slot inactive, no miss_pulse; 256+ misses -> miss_count holds 255.
REQ-039 Bench: resetn low mid-scan with 4 active slots -> all outputs zero asynchronously, busy=0, spawn_ready=1 after release.
